// File: rtl/csr_access_ctrl_if.sv
// Bundles the request/response handshake and the CSR-file bus of csr_access_ctrl.
// The controller uses the slave view; the execute stage / CSR file side uses master.
interface csr_access_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic [1:0]        req_op_i;
  logic              req_wr_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_illegal_o;

  logic [ADDR_W-1:0] csr_addr_o;
  logic [DATA_W-1:0] csr_rdata_i;
  logic              csr_hit_i;
  logic              csr_we_o;
  logic [DATA_W-1:0] csr_wdata_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_op_i, req_wr_i,
    input  rsp_ready_i, csr_rdata_i, csr_hit_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_illegal_o,
    output csr_addr_o, csr_we_o, csr_wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_op_i, req_wr_i,
    output rsp_ready_i, csr_rdata_i, csr_hit_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_illegal_o,
    input  csr_addr_o, csr_we_o, csr_wdata_o
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences one CSR instruction at a time: read old value, check legality,
// optionally write the read-modify-write result, then return the old value.
module csr_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  csr_access_ctrl_if.slave   bus,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic              illegal_q, illegal_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;

  logic              read_illegal;
  logic [DATA_W-1:0] rmw_value;

  // Outputs are registered one state ahead, so the write value is built from
  // the live read data while still in READ.
  always_comb begin
    read_illegal = !bus.csr_hit_i | (op_q == 2'b11) |
                   (wr_q & (addr_q[ADDR_W-1 -: 2] == 2'b11));

    unique case (op_q)
      2'b01:   rmw_value = bus.csr_rdata_i | data_q;
      2'b10:   rmw_value = bus.csr_rdata_i & ~data_q;
      default: rmw_value = data_q;
    endcase

    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    wr_d        = wr_q;
    old_d       = old_q;
    illegal_d   = illegal_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    we_d        = 1'b0;
    wdata_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d      = bus.req_addr_i;
          data_d      = bus.req_data_i;
          op_d        = bus.req_op_i;
          wr_d        = bus.req_wr_i;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        old_d     = bus.csr_rdata_i;
        illegal_d = read_illegal;
        if (read_illegal || !wr_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = read_illegal ? '0 : bus.csr_rdata_i;
          state_d     = RESP;
        end else begin
          we_d    = 1'b1;
          wdata_d = rmw_value;
          state_d = WRITE;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = old_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          illegal_d   = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
      wr_q        <= 1'b0;
      old_q       <= '0;
      illegal_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      wr_q        <= wr_d;
      old_q       <= old_d;
      illegal_q   <= illegal_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_data_o    = rsp_data_q;
  assign bus.rsp_illegal_o = illegal_q;
  assign bus.csr_addr_o    = addr_q;
  assign bus.csr_we_o      = we_q;
  assign bus.csr_wdata_o   = wdata_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Randomized bench for csr_access_ctrl: a CSR file model answers reads and
// takes writes, while a shadow register image predicts every response.
module tb_csr_access_ctrl;

  logic clk;
  logic rst;
  logic busy;

  csr_access_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  csr_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  bit          hit_map [0:4095];

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The CSR file: combinational read, write on the strobe.
  assign bus.csr_rdata_i = csr_mem[bus.csr_addr_o];
  assign bus.csr_hit_i   = hit_map[bus.csr_addr_o];
  always @(posedge clk) begin
    if (bus.csr_we_o) csr_mem[bus.csr_addr_o] <= bus.csr_wdata_o;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_cnt++;
    if (observed !== expected) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic randomizeRequest();
    bus.req_addr_i = 12'($urandom);
    bus.req_data_i = $urandom;
    bus.req_op_i   = 2'($urandom);
    bus.req_wr_i   = 1'($urandom);
  endtask

  function automatic logic [31:0] expectedWrite(input logic [1:0] op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] operand);
    case (op)
      2'b01:   return old_val | operand;
      2'b10:   return old_val & ~operand;
      default: return operand;
    endcase
  endfunction

  // One full transaction, entered and left on a negedge with the DUT idle.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data,
                               input logic [1:0] op, input logic wr,
                               input int hold, input bit noise);
    logic        exp_illegal;
    logic        exp_we;
    logic [31:0] exp_old;
    logic [31:0] exp_wdata;
    int          exp_lat;
    int          cyc;
    int          rsp_cyc;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] got_wdata;

    exp_illegal = !hit_map[addr] || (op == 2'b11) || (wr && (addr[11:10] == 2'b11));
    exp_we      = !exp_illegal && wr;
    exp_old     = exp_illegal ? 32'h0 : ref_mem[addr];
    exp_wdata   = expectedWrite(op, ref_mem[addr], data);
    exp_lat     = exp_we ? 3 : 2;

    checkOutput("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.req_op_i    = op;
    bus.req_wr_i    = wr;
    @(negedge clk);
    cyc       = 1;
    rsp_cyc   = -1;
    we_cnt    = 0;
    we_cyc    = -1;
    got_wdata = 32'h0;
    bus.req_valid_i = noise;
    if (noise) randomizeRequest();

    while (rsp_cyc < 0 && cyc <= 8) begin
      checkOutput("csr_addr", 64'(bus.csr_addr_o), 64'(addr));
      checkOutput("req_ready_busy", 64'(bus.req_ready_o), 64'd0);
      if (bus.csr_we_o) begin
        we_cnt++;
        we_cyc    = cyc;
        got_wdata = bus.csr_wdata_o;
      end else begin
        checkOutput("wdata_quiet", 64'(bus.csr_wdata_o), 64'd0);
      end
      if (bus.rsp_valid_o) begin
        rsp_cyc = cyc;
      end else begin
        bus.rsp_ready_i = 1'($urandom);
        if (noise) randomizeRequest();
        @(negedge clk);
        cyc++;
      end
    end

    checkOutput("we_count", 64'(we_cnt), exp_we ? 64'd1 : 64'd0);
    if (exp_we) begin
      checkOutput("we_cycle", 64'(we_cyc), 64'd2);
      checkOutput("wdata", 64'(got_wdata), 64'(exp_wdata));
      ref_mem[addr] = exp_wdata;
    end

    if (rsp_cyc < 0) begin
      checkOutput("rsp_timeout", 64'd0, 64'd1);
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
    end else begin
      checkOutput("rsp_latency", 64'(rsp_cyc), 64'(exp_lat));
      for (int h = 0; h <= hold; h++) begin
        checkOutput("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        checkOutput("rsp_data", 64'(bus.rsp_data_o), 64'(exp_old));
        checkOutput("rsp_illegal", 64'(bus.rsp_illegal_o), 64'(exp_illegal));
        checkOutput("resp_no_we", 64'(bus.csr_we_o), 64'd0);
        checkOutput("resp_req_ready", 64'(bus.req_ready_o), 64'd0);
        checkOutput("resp_busy", 64'(busy), 64'd1);
        checkOutput("resp_addr", 64'(bus.csr_addr_o), 64'(addr));
        if (h < hold) begin
          bus.rsp_ready_i = 1'b0;
          if (noise) randomizeRequest();
        end else begin
          bus.rsp_ready_i = 1'b1;
          bus.req_valid_i = 1'b0;
        end
        @(negedge clk);
      end
      bus.rsp_ready_i = 1'b0;
      checkOutput("rsp_done_valid", 64'(bus.rsp_valid_o), 64'd0);
      checkOutput("rsp_done_ready", 64'(bus.req_ready_o), 64'd1);
      checkOutput("rsp_done_busy", 64'(busy), 64'd0);
    end
  endtask

  // Starts a legal write and resets the controller while the strobe is high.
  task automatic resetDuringWrite(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] exp_wdata;
    exp_wdata = expectedWrite(2'b00, ref_mem[addr], data);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.req_op_i    = 2'b00;
    bus.req_wr_i    = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_write_we", 64'(bus.csr_we_o), 64'd1);
    checkOutput("rst_write_wdata", 64'(bus.csr_wdata_o), 64'(exp_wdata));
    ref_mem[addr] = exp_wdata;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_idle_ready", 64'(bus.req_ready_o), 64'd1);
    checkOutput("rst_idle_busy", 64'(busy), 64'd0);
    checkOutput("rst_idle_we", 64'(bus.csr_we_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_after_we", 64'(bus.csr_we_o), 64'd0);
      checkOutput("rst_after_rsp", 64'(bus.rsp_valid_o), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] addr_pool [8];
    addr_pool = '{12'h300, 12'h340, 12'h305, 12'hC00, 12'hF11, 12'h7C0, 12'h341, 12'hB00};

    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      hit_map[i] = 1'b1;
    end
    hit_map[12'h7C0] = 1'b0;
    csr_mem[12'h340] = 32'h0000_1234;
    csr_mem[12'h300] = 32'h0000_0008;
    for (int i = 0; i < 4096; i++) ref_mem[i] = csr_mem[i];

    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_op_i    = '0;
    bus.req_wr_i    = 1'b0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_req_ready", 64'(bus.req_ready_o), 64'd1);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    checkOutput("reset_rsp_data", 64'(bus.rsp_data_o), 64'd0);
    checkOutput("reset_rsp_illegal", 64'(bus.rsp_illegal_o), 64'd0);
    checkOutput("reset_csr_addr", 64'(bus.csr_addr_o), 64'd0);
    checkOutput("reset_we", 64'(bus.csr_we_o), 64'd0);
    checkOutput("reset_wdata", 64'(bus.csr_wdata_o), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);

    $display("[TB] directed transactions");
    applyStimulus(12'h340, 32'h0000_A5A5, 2'b00, 1'b1, 0, 1'b0);
    applyStimulus(12'h300, 32'h0000_0080, 2'b01, 1'b1, 0, 1'b0);
    applyStimulus(12'h300, 32'h0000_0008, 2'b10, 1'b1, 0, 1'b0);
    checkOutput("rmw_chain_final", 64'(csr_mem[12'h300]), 64'h80);
    applyStimulus(12'hC00, 32'h0000_0000, 2'b01, 1'b0, 1, 1'b0);
    applyStimulus(12'hF11, 32'hDEAD_BEEF, 2'b00, 1'b1, 0, 1'b0);
    applyStimulus(12'h7C0, 32'h0000_00FF, 2'b01, 1'b1, 0, 1'b0);
    applyStimulus(12'h340, 32'h0000_00FF, 2'b11, 1'b1, 0, 1'b0);
    applyStimulus(12'h340, 32'h5A5A_0000, 2'b01, 1'b1, 5, 1'b1);

    $display("[TB] reset during write");
    resetDuringWrite(12'h305, 32'hCAFE_F00D);
    applyStimulus(12'h305, 32'h0000_0000, 2'b01, 1'b0, 0, 1'b0);

    $display("[TB] random transactions");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(addr_pool[$urandom_range(0, 7)], $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 8; k++) begin
      checkOutput("final_image", 64'(csr_mem[addr_pool[k]]), 64'(ref_mem[addr_pool[k]]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
